// File: rtl/smi_pkg.sv
// Shared SMI definitions: write-assembler state encoding, test-pattern seed and
// the pattern LFSR step also used by the read-side generator.
package smi_pkg;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PUSH = 1'b1;

  localparam logic [7:0] SMI_TEST_SEED = 8'h56;

  // A zero state would lock up the LFSR, so it reseeds instead.
  function automatic logic [7:0] smi_lfsr_next(input logic [7:0] v);
    logic [7:0] n;
    n = {v[2] ^ v[3], v[7:1]};
    return (n == 8'h00) ? SMI_TEST_SEED : n;
  endfunction

endpackage

// File: rtl/smi_strobe_sync.sv
// SYNC_STAGES-deep synchronizer for an async strobe plus its data bus, with
// rising/falling edge detect on the synchronized strobe. Idle state is all-1.
module smi_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8
) (
  input  logic          i_sys_clk,
  input  logic          i_rst_b,
  input  logic          strb_i,
  input  logic [DW-1:0] data_i,
  output logic          rise_o,
  output logic          fall_o,
  output logic [DW-1:0] data_o
);

  logic [SYNC_STAGES-1:0]         strb_q;
  logic [SYNC_STAGES-1:0][DW-1:0] data_q;
  logic                           strb_prev_q;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      strb_q      <= '1;
      data_q      <= '1;
      strb_prev_q <= 1'b1;
    end else begin
      strb_q      <= {strb_q[SYNC_STAGES-2:0], strb_i};
      data_q      <= {data_q[SYNC_STAGES-2:0], data_i};
      strb_prev_q <= strb_q[SYNC_STAGES-1];
    end
  end

  // Data leaves the chain in the same cycle as the strobe edge it belongs to.
  assign rise_o = strb_q[SYNC_STAGES-1] & ~strb_prev_q;
  assign fall_o = ~strb_q[SYNC_STAGES-1] & strb_prev_q;
  assign data_o = data_q[SYNC_STAGES-1];

endmodule

// File: rtl/smi_wr_assembler.sv
// SMI host write path: packs strobed bytes MSB-first into 32-bit TX FIFO words.
// Optional test-pattern checker enabled by SMI_WR_PATTERN_CHECK_EN.
module smi_wr_assembler
  import smi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic        i_wr_en,
  input  logic        i_smi_swe_srw,
  input  logic [7:0]  i_smi_data_in,
  input  logic        i_smi_test,
  output logic        o_smi_write_req,
  output logic        o_fifo_push,
  output logic [31:0] o_fifo_pushed_data,
  input  logic        i_fifo_full,
  input  logic        i_clear_err,
  output logic        o_overflow_err,
  output logic [7:0]  o_test_err_cnt
);

  logic       strb_rise, unused_fall;
  logic [7:0] sdata;

  smi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .DW(8)) u_sync (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .strb_i    (i_smi_swe_srw),
    .data_i    (i_smi_data_in),
    .rise_o    (strb_rise),
    .fall_o    (unused_fall),
    .data_o    (sdata)
  );

  logic byte_evt, asm_evt;
  assign byte_evt = strb_rise & i_wr_en;
  assign asm_evt  = byte_evt & ~i_smi_test;

  logic [0:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        push_q, push_d;
  logic        ovf_q, ovf_d;
  logic        pend_q, pend_d;
  logic [7:0]  pbyte_q, pbyte_d;
  logic        run_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    push_d  = 1'b0;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    pbyte_d = pbyte_q;
    case (state_q)
      ST_FILL: begin
        if (!i_wr_en || i_smi_test) begin
          idx_d  = 2'd0;
          pend_d = 1'b0;
        end else if (pend_q) begin
          // Byte caught on the push-decision cycle; lands once the push is seen.
          word_d[31:24] = pbyte_q;
          idx_d         = 2'd1;
          pend_d        = 1'b0;
        end else if (asm_evt) begin
          word_d[{~idx_q, 3'b000} +: 8] = sdata;
          if (idx_q == 2'd3) state_d = ST_PUSH;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      default: begin
        if (!i_fifo_full) begin
          push_d  = 1'b1;
          state_d = ST_FILL;
          idx_d   = 2'd0;
          if (asm_evt) begin
            pend_d  = 1'b1;
            pbyte_d = sdata;
          end
        end else if (asm_evt) begin
          ovf_d = 1'b1;
        end
      end
    endcase
    if (i_clear_err) ovf_d = 1'b0;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q <= ST_FILL;
      idx_q   <= 2'd0;
      word_q  <= '0;
      push_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      pbyte_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      push_q  <= push_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      pbyte_q <= pbyte_d;
      run_q   <= 1'b1;
    end
  end

  assign o_fifo_push        = push_q;
  assign o_fifo_pushed_data = word_q;
  assign o_overflow_err     = ovf_q;
  assign o_smi_write_req    = run_q & i_wr_en & ~i_smi_test & (state_q == ST_FILL) & ~i_fifo_full;

`ifdef SMI_WR_PATTERN_CHECK_EN
  logic       test_evt;
  logic [7:0] exp_q, exp_d;
  logic [7:0] cnt_q, cnt_d;
  assign test_evt = byte_evt & i_smi_test;

  always_comb begin
    exp_d = exp_q;
    cnt_d = cnt_q;
    if (test_evt) begin
      exp_d = smi_lfsr_next(exp_q);
      if (sdata != exp_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
    if (i_clear_err) cnt_d = 8'h00;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      exp_q <= SMI_TEST_SEED;
      cnt_q <= 8'h00;
    end else begin
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_test_err_cnt = cnt_q;
`else
  assign o_test_err_cnt = 8'h00;
`endif

endmodule
